// File: rtl/name_pattern.sv
// Serial ASCII detector for the keyword "IMTIYAZ": one byte per clock, and a
// registered one-cycle pulse on eurika each time the last seven bytes spell it.
module name_pattern (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] letter,
    output logic       eurika
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6,
        S7 = 3'd7
    } state_t;

    localparam logic [7:0] CH_I = 8'h49;
    localparam logic [7:0] CH_M = 8'h4D;
    localparam logic [7:0] CH_T = 8'h54;
    localparam logic [7:0] CH_Y = 8'h59;
    localparam logic [7:0] CH_A = 8'h41;
    localparam logic [7:0] CH_Z = 8'h5A;

    state_t state;
    state_t state_nxt;

    // Each state is the longest pattern prefix that is also a suffix of the
    // input so far; only S4 ("IMTI") can fall back to a two-char prefix.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = S0;
        case (state)
            S0: if (letter == CH_I) state_nxt = S1;
            S1: if (letter == CH_M) state_nxt = S2;
                else if (letter == CH_I) state_nxt = S1;
            S2: if (letter == CH_T) state_nxt = S3;
                else if (letter == CH_I) state_nxt = S1;
            S3: if (letter == CH_I) state_nxt = S4;
            S4: if (letter == CH_Y) state_nxt = S5;
                else if (letter == CH_M) state_nxt = S2;
                else if (letter == CH_I) state_nxt = S1;
            S5: if (letter == CH_A) state_nxt = S6;
                else if (letter == CH_I) state_nxt = S1;
            S6: if (letter == CH_Z) state_nxt = S7;
                else if (letter == CH_I) state_nxt = S1;
            S7: if (letter == CH_I) state_nxt = S1;
            default: state_nxt = S0;
        endcase
    end

    // eurika is registered from the next state so it rises on the edge that
    // samples 'Z' without any combinational path from letter to the output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S0;
            eurika <= 1'b0;
        end else begin
            // NOTE: non-blocking so state and eurika update together from pre-edge values.
            state  <= state_nxt;
            eurika <= (state_nxt == S7);
        end
    end

endmodule

// File: tb/tb_name_pattern.sv
// Self-checking bench for name_pattern: directed scenarios plus a random byte
// stream, compared against a sliding seven-character history model.
module tb_name_pattern;

    logic       clk;
    logic       rst;
    logic [7:0] letter;
    logic       eurika;

    int vectors;
    int miscompares;

    localparam logic [55:0] PATTERN = "IMTIYAZ";

    logic [55:0] hist;
    int          hist_len;

    name_pattern dut (
        .clk    (clk),
        .rst    (rst),
        .letter (letter),
        .eurika (eurika)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic actual, input logic expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: eurika=%b expected=%b at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic model_match();
        return (hist_len >= 7) && (hist == PATTERN);
    endfunction

    // Drive a byte away from the edge, then check the flag just after the edge.
    task automatic send(input logic [7:0] c, input string tag);
        @(negedge clk);
        letter = c;
        @(posedge clk);
        hist = {hist[47:0], c};
        if (hist_len < 7) hist_len++;
        #1;
        check(tag, eurika, model_match());
    endtask

    task automatic send_str(input string s, input string tag);
        for (int i = 0; i < s.len(); i++) send(s[i], tag);
    endtask

    // Async reset asserted between edges; flag must clear without a clock edge.
    task automatic pulse_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        check(tag, eurika, 1'b0);
        hist = '0;
        hist_len = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        string pool;
        vectors     = 0;
        miscompares = 0;
        hist        = '0;
        hist_len    = 0;
        letter      = "p";
        rst         = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("reset_hold", eurika, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) send("p", "idle");

        send_str("IMTIMTIYAZAI", "overlap");
        send_str("IMTIYAZIMTIYAZ", "back_to_back");
        send_str("imtiyaz", "lowercase");
        send_str("IMTIYAX", "near_miss_x");
        send_str("IMTIYZ", "near_miss_short");
        send_str("IIIMTIYAZ", "repeat_i");

        // Reset while the flag is high must drop it immediately.
        send_str("pIMTIYAZ", "pre_async");
        check("flag_set", eurika, 1'b1);
        pulse_reset("async_clear");

        // Partial progress must be discarded by reset.
        send_str("IMTIYA", "mid_pattern");
        pulse_reset("mid_reset");
        send("Z", "after_reset_z");
        send_str("IMTIYAZ", "after_reset_full");
        send(8'h00, "nul");

        // Random stream biased towards pattern letters so partial matches are common.
        pool = "IMTIYAZ";
        for (int n = 0; n < 3000; n++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 5)
                send_str("IMTIYAZ", "rand_pattern");
            else if (sel < 7)
                send_str("IMTI", "rand_prefix");
            else if (sel < 70)
                send(pool[$urandom_range(0, 6)], "rand_letter");
            else if (sel < 99)
                send(8'($urandom_range(0, 255)), "rand_byte");
            else
                pulse_reset("rand_reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
